// File: rtl/mem_model_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_model_pkg
// Description : Shared types and default constants for the multi-channel
//               slow memory model (channel FSM states, parameter defaults).
// Revision    : 1.0 - initial release
// ============================================================================
package mem_model_pkg;

  // Per-channel request lifecycle
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Default build constants
  localparam int C_NUM_CH  = 2;
  localparam int C_LINE_W  = 128;
  localparam int C_ADDR_W  = 28;
  localparam int C_DEPTH   = 256;
  localparam int C_LATENCY = 4;

  // Latency counter width; covers LATENCY up to 15
  localparam int C_CNT_W   = 4;

endpackage : mem_model_pkg
`default_nettype wire

// File: rtl/multi_slow_mem_channel.sv
`default_nettype none
// ============================================================================
// Module      : mem_channel
// Description : One independent slow-memory channel: request FSM, latency
//               counter, private line bank and held read-data register.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_channel
  import mem_model_pkg::*;
#(
  parameter int LINE_W  = C_LINE_W,
  parameter int ADDR_W  = C_ADDR_W,
  parameter int DEPTH   = C_DEPTH,
  parameter int LATENCY = C_LATENCY
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_read,
  input  logic                     i_write,
  input  logic [ADDR_W-1:0]        i_addr,
  input  logic [LINE_W-1:0]        i_wdata,
  input  logic                     i_ld_en,
  input  logic [$clog2(DEPTH)-1:0] i_ld_idx,
  input  logic [LINE_W-1:0]        i_ld_data,
  output logic [LINE_W-1:0]        o_rdata,
  output logic                     o_ready
);

  localparam int                 IDX_W      = $clog2(DEPTH);
  localparam logic [C_CNT_W-1:0] C_CNT_INIT = C_CNT_W'(LATENCY - 1);
  localparam logic [C_CNT_W-1:0] C_CNT_ONE  = C_CNT_W'(1);

  state_t               r_state;
  state_t               w_state_nxt;
  logic [C_CNT_W-1:0]   r_cnt;
  logic [C_CNT_W-1:0]   w_cnt_nxt;
  logic [IDX_W-1:0]     r_idx;
  logic [LINE_W-1:0]    r_wdata;
  logic                 r_wr;
  logic [LINE_W-1:0]    r_rdata;
  logic                 w_accept;
  logic                 w_fill;
  logic [IDX_W-1:0]     w_fill_idx;
  logic [LINE_W-1:0]    w_fill_data;
  logic                 w_commit;
  logic [LINE_W-1:0]    r_bank [DEPTH];

  // Upper address bits only alias onto the bank; fold them so they are consumed
  if (ADDR_W > IDX_W) begin : g_addr_hi
    logic w_unused_addr_hi;
    assign w_unused_addr_hi = ^i_addr[ADDR_W-1:IDX_W];
  end

  // Next-state, counter and read-fill decision
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_accept    = 1'b0;
    w_fill      = 1'b0;
    w_fill_idx  = r_idx;
    case (r_state)
      IDLE: begin
        // With LATENCY=1 the read resolves at the acceptance edge itself
        w_fill_idx = i_addr[IDX_W-1:0];
        if (i_read || i_write) begin
          w_accept = 1'b1;
          if (LATENCY == 1) begin
            w_state_nxt = DONE;
            w_cnt_nxt   = '0;
            w_fill      = !i_write;
          end else begin
            w_state_nxt = BUSY;
            w_cnt_nxt   = C_CNT_INIT;
          end
        end
      end
      BUSY: begin
        w_cnt_nxt = r_cnt - C_CNT_ONE;
        if (r_cnt <= C_CNT_ONE) begin
          w_state_nxt = DONE;
          w_cnt_nxt   = '0;
          w_fill      = !r_wr;
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // A preload landing on the same edge as the read capture must be seen by it
  assign w_fill_data = (i_ld_en && (i_ld_idx == w_fill_idx)) ? i_ld_data : r_bank[w_fill_idx];

  // Pending write is dropped if reset coincides with its commit edge
  assign w_commit = (r_state == DONE) && r_wr && !rst;

  assign o_ready = (r_state == DONE);
  assign o_rdata = r_rdata;

  // FSM state and latency counter
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Capture of the accepted request
  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx   <= '0;
      r_wdata <= '0;
      r_wr    <= 1'b0;
    end else if (w_accept) begin
      r_idx   <= i_addr[IDX_W-1:0];
      r_wdata <= i_wdata;
      r_wr    <= i_write;
    end
  end

  // Read data register, held until the next read completes
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdata <= '0;
    end else if (w_fill) begin
      r_rdata <= w_fill_data;
    end
  end

  // Bank storage: never reset; channel write ordered last so it wins a collision
  always_ff @(posedge clk) begin
    if (i_ld_en) begin
      r_bank[i_ld_idx] <= i_ld_data;
    end
    if (w_commit) begin
      r_bank[r_idx] <= r_wdata;
    end
  end

endmodule : mem_channel
`default_nettype wire

// File: rtl/multi_slow_mem.sv
`default_nettype none
// ============================================================================
// Module      : multi_slow_mem
// Description : Multi-channel fixed-latency memory model. Each channel owns
//               a private bank; a backdoor preload port targets any channel.
// Revision    : 1.0 - initial release
// ============================================================================
module multi_slow_mem
  import mem_model_pkg::*;
#(
  parameter int NUM_CH  = C_NUM_CH,
  parameter int LINE_W  = C_LINE_W,
  parameter int ADDR_W  = C_ADDR_W,
  parameter int DEPTH   = C_DEPTH,
  parameter int LATENCY = C_LATENCY
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH-1:0]        mem_read,
  input  logic [NUM_CH-1:0]        mem_write,
  input  logic [NUM_CH*ADDR_W-1:0] mem_addr,
  input  logic [NUM_CH*LINE_W-1:0] mem_wdata,
  output logic [NUM_CH*LINE_W-1:0] mem_rdata,
  output logic [NUM_CH-1:0]        mem_ready,
  input  logic                     load_en,
  input  logic [2:0]               load_ch,
  input  logic [$clog2(DEPTH)-1:0] load_addr,
  input  logic [LINE_W-1:0]        load_data
);

  logic [NUM_CH-1:0] w_ld_sel;

  // One channel per generate iteration; preload strobe decoded per channel
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    assign w_ld_sel[c] = load_en && (load_ch == 3'(c));

    mem_channel #(
      .LINE_W  (LINE_W),
      .ADDR_W  (ADDR_W),
      .DEPTH   (DEPTH),
      .LATENCY (LATENCY)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .i_read    (mem_read[c]),
      .i_write   (mem_write[c]),
      .i_addr    (mem_addr[c*ADDR_W +: ADDR_W]),
      .i_wdata   (mem_wdata[c*LINE_W +: LINE_W]),
      .i_ld_en   (w_ld_sel[c]),
      .i_ld_idx  (load_addr),
      .i_ld_data (load_data),
      .o_rdata   (mem_rdata[c*LINE_W +: LINE_W]),
      .o_ready   (mem_ready[c])
    );
  end

endmodule : multi_slow_mem
`default_nettype wire
